// File: rtl/sos_cascade_tm.sv
// Biquad cascade sharing one time-multiplexed MAC, runtime-loadable coefficients.
// Define SOS_CASCADE_SAT_EN for saturating stage outputs (default: wrap).
module sos_cascade_tm #(
  parameter int DATA_SIZE = 24,
  parameter int COEF_SIZE = 20,
  parameter int FRAC_BITS = 18,
  parameter int N_STAGES  = 2,
  parameter int ADDR_W    = $clog2(6*N_STAGES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_trig,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 coef_we,
  input  logic [ADDR_W-1:0]    coef_addr,
  input  logic [COEF_SIZE-1:0] coef_wdata,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 filter_end,
  output logic                 busy,
  output logic                 overrun
);

  localparam int PROD_W = DATA_SIZE + COEF_SIZE;
  localparam int ACC_W  = DATA_SIZE + COEF_SIZE + 3;
  localparam int SW     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [SW-1:0] LAST = SW'(N_STAGES - 1);
  localparam logic signed [COEF_SIZE-1:0] ONE =
    {{(COEF_SIZE-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    GAIN,
    UPDATE,
    DONE
  } state_t;

  state_t         state;
  logic [2:0]     mac_cnt;
  logic [SW-1:0]  stage;

  logic signed [COEF_SIZE-1:0] coef [N_STAGES][6];
  logic signed [DATA_SIZE-1:0] x1 [N_STAGES];
  logic signed [DATA_SIZE-1:0] x2 [N_STAGES];
  logic signed [DATA_SIZE-1:0] y1 [N_STAGES];
  logic signed [DATA_SIZE-1:0] y2 [N_STAGES];

  logic signed [DATA_SIZE-1:0] cur_x;
  logic signed [DATA_SIZE-1:0] y_reg;
  logic signed [DATA_SIZE-1:0] out_reg;
  logic signed [ACC_W-1:0]     acc;

  logic signed [COEF_SIZE-1:0] mul_c;
  logic signed [DATA_SIZE-1:0] mul_d;
  logic                        sub;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     prod_x;
  logic signed [ACC_W-1:0]     acc_sh;
  logic signed [ACC_W-1:0]     g_sh;
  logic signed [DATA_SIZE-1:0] y_c;
  logic signed [DATA_SIZE-1:0] out_c;

  logic accept;
  logic wr_ok;

  assign accept = (state == IDLE) && !busy && sample_trig;
  assign wr_ok  = (state == IDLE) && !busy && !sample_trig && coef_we;

  always_comb begin
    mul_c = coef[stage][0];
    mul_d = cur_x;
    sub   = 1'b0;
    if (state == GAIN) begin
      mul_c = coef[stage][5];
      mul_d = y_c;
    end else begin
      unique case (mac_cnt)
        3'd1: begin
          mul_c = coef[stage][1];
          mul_d = x1[stage];
        end
        3'd2: begin
          mul_c = coef[stage][2];
          mul_d = x2[stage];
        end
        3'd3: begin
          mul_c = coef[stage][3];
          mul_d = y1[stage];
          sub   = 1'b1;
        end
        3'd4: begin
          mul_c = coef[stage][4];
          mul_d = y2[stage];
          sub   = 1'b1;
        end
        default: begin
          mul_c = coef[stage][0];
          mul_d = cur_x;
        end
      endcase
    end
  end

  assign prod   = mul_c * mul_d;
  assign prod_x = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_sh = acc >>> FRAC_BITS;
  assign g_sh   = prod_x >>> FRAC_BITS;

`ifdef SOS_CASCADE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  function automatic logic signed [DATA_SIZE-1:0] fmt(
    input logic signed [ACC_W-1:0] v
  );
    logic signed [ACC_W-1:0] r;
    r = v;
    if (v > SAT_MAX) r = SAT_MAX;
    if (v < SAT_MIN) r = SAT_MIN;
    return r[DATA_SIZE-1:0];
  endfunction

  assign y_c   = fmt(acc_sh);
  assign out_c = fmt(g_sh);
`else
  logic unused_hi;
  assign unused_hi = ^{acc_sh[ACC_W-1:DATA_SIZE], g_sh[ACC_W-1:DATA_SIZE]};
  assign y_c   = acc_sh[DATA_SIZE-1:0];
  assign out_c = g_sh[DATA_SIZE-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      mac_cnt    <= 3'd0;
      stage      <= '0;
      busy       <= 1'b0;
      filter_end <= 1'b0;
      overrun    <= 1'b0;
      data_out   <= '0;
    end else begin
      filter_end <= 1'b0;
      if (sample_trig && busy) overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (sample_trig) begin
            busy    <= 1'b1;
            stage   <= '0;
            mac_cnt <= 3'd0;
            state   <= MAC;
          end
        end
        MAC: begin
          if (mac_cnt == 3'd4) begin
            mac_cnt <= 3'd0;
            state   <= GAIN;
          end else begin
            mac_cnt <= mac_cnt + 3'd1;
          end
        end
        GAIN: state <= UPDATE;
        UPDATE: begin
          mac_cnt <= 3'd0;
          if (stage == LAST) begin
            state <= DONE;
          end else begin
            stage <= stage + SW'(1);
            state <= MAC;
          end
        end
        DONE: begin
          data_out   <= cur_x;
          filter_end <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_x   <= '0;
      y_reg   <= '0;
      out_reg <= '0;
      acc     <= '0;
      for (int s = 0; s < N_STAGES; s++) begin
        x1[s] <= '0;
        x2[s] <= '0;
        y1[s] <= '0;
        y2[s] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) cur_x <= data_in;
        end
        MAC: begin
          if (mac_cnt == 3'd0) acc <= prod_x;
          else if (sub)        acc <= acc - prod_x;
          else                 acc <= acc + prod_x;
        end
        GAIN: begin
          y_reg   <= y_c;
          out_reg <= out_c;
        end
        UPDATE: begin
          x2[stage] <= x1[stage];
          x1[stage] <= cur_x;
          y2[stage] <= y1[stage];
          y1[stage] <= y_reg;
          cur_x     <= out_reg;
        end
        default: ;
      endcase
    end
  end

  // Out-of-range addresses match no entry and fall through untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < N_STAGES; s++) begin
        for (int i = 0; i < 6; i++) begin
          coef[s][i] <= (i == 0 || i == 5) ? ONE : '0;
        end
      end
    end else if (wr_ok) begin
      for (int s = 0; s < N_STAGES; s++) begin
        for (int i = 0; i < 6; i++) begin
          if (coef_addr == ADDR_W'(s*6 + i)) coef[s][i] <= coef_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_sos_cascade_tm.sv
// Bench for sos_cascade_tm: directed scenarios plus random samples
// against an integer reference of the biquad cascade.
module tb_sos_cascade_tm;

  localparam int D  = 24;
  localparam int C  = 20;
  localparam int N  = 2;
  localparam int AW = 4;
  localparam int NC = 6*N;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sample_trig = 1'b0;
  logic [D-1:0]  data_in = '0;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [C-1:0]  coef_wdata = '0;
  logic [D-1:0]  data_out;
  logic          filter_end;
  logic          busy;
  logic          overrun;

  sos_cascade_tm #(
    .DATA_SIZE(D), .COEF_SIZE(C), .FRAC_BITS(18), .N_STAGES(N)
  ) dut (
    .clk(clk), .reset(reset), .sample_trig(sample_trig),
    .data_in(data_in), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .data_out(data_out),
    .filter_end(filter_end), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  longint mc [NC];
  longint hx1 [N];
  longint hx2 [N];
  longint hy1 [N];
  longint hy2 [N];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic longint sext(longint v, int w);
    longint r;
    r = v & ((longint'(1) << w) - 1);
    if (r >= (longint'(1) << (w-1))) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic longint fmt(longint v);
`ifdef SOS_CASCADE_SAT_EN
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
`else
    return sext(v, D);
`endif
  endfunction

  task automatic model_reset;
    for (int i = 0; i < NC; i++)
      mc[i] = (i % 6 == 0 || i % 6 == 5) ? 262144 : 0;
    for (int s = 0; s < N; s++) begin
      hx1[s] = 0; hx2[s] = 0; hy1[s] = 0; hy2[s] = 0;
    end
  endtask

  task automatic model_step(input longint xin, output logic [D-1:0] res);
    longint x, acc, y, o;
    x = sext(xin, D);
    for (int s = 0; s < N; s++) begin
      acc = mc[s*6]*x + mc[s*6+1]*hx1[s] + mc[s*6+2]*hx2[s]
          - mc[s*6+3]*hy1[s] - mc[s*6+4]*hy2[s];
      y = fmt(acc >>> 18);
      o = fmt((mc[s*6+5]*y) >>> 18);
      hx2[s] = hx1[s]; hx1[s] = x;
      hy2[s] = hy1[s]; hy1[s] = y;
      x = o;
    end
    res = x[D-1:0];
  endtask

  task automatic do_reset;
    reset = 1'b0; sample_trig = 1'b0; coef_we = 1'b0;
    tick; tick;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic coef_write(input int addr, input longint val);
    coef_addr = AW'(addr); coef_wdata = C'(val); coef_we = 1'b1;
    tick;
    coef_we = 1'b0;
    if (addr < NC) mc[addr] = sext(val, C);
  endtask

  task automatic run_sample(input longint din, output logic [D-1:0] res,
                            output int lat);
    data_in = D'(din); sample_trig = 1'b1;
    tick;
    sample_trig = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      tick;
      if (filter_end) begin lat = i; break; end
    end
    res = data_out;
    if (lat > 0) tick;
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (data_out !== '0) begin bad++;
      $display("FAIL reset_data_out got=%0h want=0", data_out); end
    total++; if (filter_end !== 1'b0) begin bad++;
      $display("FAIL reset_filter_end got=%b want=0", filter_end); end
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++;
      $display("FAIL reset_overrun got=%b want=0", overrun); end
  endtask

  task automatic test_passthrough;
    logic [D-1:0] r, e;
    int lat;
    model_step(1000, e);
    run_sample(1000, r, lat);
    total++; if (lat !== 15) begin bad++;
      $display("FAIL pass_latency got=%0d want=15", lat); end
    total++; if (r !== 24'd1000) begin bad++;
      $display("FAIL pass_value got=%0d want=1000", r); end
    total++; if (r !== e) begin bad++;
      $display("FAIL pass_model got=%0h want=%0h", r, e); end
    total++; if (busy !== 1'b0 || filter_end !== 1'b0) begin bad++;
      $display("FAIL pass_after got=%b%b want=00", busy, filter_end); end
    tick; tick;
    total++; if (data_out !== 24'd1000) begin bad++;
      $display("FAIL pass_hold got=%0d want=1000", data_out); end
  endtask

  task automatic test_scale;
    logic [D-1:0] r, e;
    int lat;
    coef_write(0, 131072);
    coef_write(11, 131072);
    model_step(4000, e);
    run_sample(4000, r, lat);
    total++; if (r !== 24'd1000) begin bad++;
      $display("FAIL scale_value got=%0d want=1000", r); end
    total++; if (r !== e) begin bad++;
      $display("FAIL scale_model got=%0h want=%0h", r, e); end
  endtask

  task automatic impulse_seq(input string tag);
    logic [D-1:0] r, e;
    int lat;
    int want [3] = '{1000, 500, 250};
    longint din [3] = '{1000, 0, 0};
    coef_write(3, -131072);
    for (int k = 0; k < 3; k++) begin
      model_step(din[k], e);
      run_sample(din[k], r, lat);
      total++; if (r !== D'(want[k]) || lat !== 15) begin bad++;
        $display("FAIL %s_%0d got=%0d lat=%0d want=%0d", tag, k, r, lat,
                 want[k]); end
      total++; if (r !== e) begin bad++;
        $display("FAIL %s_model_%0d got=%0h want=%0h", tag, k, r, e); end
    end
  endtask

  task automatic test_impulse;
    do_reset();
    impulse_seq("impulse");
  endtask

  task automatic test_overrun;
    logic [D-1:0] r, e;
    longint din;
    int lat;
    total++; if (overrun !== 1'b0) begin bad++;
      $display("FAIL ovr_pre got=%b want=0", overrun); end
    din = sext(longint'($urandom_range(0, 16'hFFFF)) - 32768, D);
    model_step(din, e);
    data_in = D'(din); sample_trig = 1'b1;
    tick;
    sample_trig = 1'b0;
    tick; tick; tick;
    data_in = D'(12345); sample_trig = 1'b1;
    coef_addr = AW'(0); coef_wdata = C'(20'h12345); coef_we = 1'b1;
    tick;
    sample_trig = 1'b0; coef_we = 1'b0;
    lat = -1;
    for (int i = 5; i <= 200; i++) begin
      tick;
      if (filter_end) begin lat = i; break; end
    end
    r = data_out;
    tick;
    total++; if (lat !== 15) begin bad++;
      $display("FAIL ovr_latency got=%0d want=15", lat); end
    total++; if (r !== e) begin bad++;
      $display("FAIL ovr_value got=%0h want=%0h", r, e); end
    total++; if (overrun !== 1'b1) begin bad++;
      $display("FAIL ovr_flag got=%b want=1", overrun); end
    model_step(777, e);
    run_sample(777, r, lat);
    total++; if (r !== e) begin bad++;
      $display("FAIL ovr_coef_kept got=%0h want=%0h", r, e); end
    total++; if (overrun !== 1'b1) begin bad++;
      $display("FAIL ovr_sticky got=%b want=1", overrun); end
  endtask

  task automatic test_saturation;
    logic [D-1:0] r, e, lit;
    int lat;
    do_reset();
    coef_write(0, 524287);
`ifdef SOS_CASCADE_SAT_EN
    lit = 24'h7FFFFF;
`else
    lit = 24'hFFFFC0;
`endif
    model_step(24'h7FFFF0, e);
    run_sample(24'h7FFFF0, r, lat);
    total++; if (r !== lit) begin bad++;
      $display("FAIL sat_value got=%0h want=%0h", r, lit); end
    total++; if (r !== e) begin bad++;
      $display("FAIL sat_model got=%0h want=%0h", r, e); end
  endtask

  task automatic test_reset_mid;
    logic [D-1:0] r, e;
    int lat, seen;
    do_reset();
    coef_write(3, -131072);
    model_step(1000, e);
    run_sample(1000, r, lat);
    data_in = D'(5555); sample_trig = 1'b1;
    tick;
    sample_trig = 1'b0;
    tick; tick;
    reset = 1'b0;
    tick;
    total++; if (busy !== 1'b0 || filter_end !== 1'b0) begin bad++;
      $display("FAIL mid_abort got=%b%b want=00", busy, filter_end); end
    reset = 1'b1;
    model_reset();
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (filter_end) seen++;
    end
    total++; if (seen !== 0) begin bad++;
      $display("FAIL mid_no_end got=%0d want=0", seen); end
    impulse_seq("mid_rerun");
  endtask

  task automatic test_random;
    logic [D-1:0] r, e;
    longint din;
    int lat;
    do_reset();
    for (int a = 0; a < NC; a++)
      coef_write(a, sext(longint'($urandom), C));
    for (int a = NC; a < 16; a++)
      coef_write(a, sext(longint'($urandom), C));
    for (int k = 0; k < 16; k++) begin
      din = sext(longint'($urandom), D);
      model_step(din, e);
      run_sample(din, r, lat);
      total++; if (r !== e || lat !== 15) begin bad++;
        $display("FAIL rand_%0d got=%0h lat=%0d want=%0h", k, r, lat, e); end
    end
    din = sext(longint'($urandom), D);
    model_step(din, e);
    data_in = D'(din); sample_trig = 1'b1;
    coef_addr = AW'(0); coef_wdata = C'($urandom); coef_we = 1'b1;
    tick;
    sample_trig = 1'b0; coef_we = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      tick;
      if (filter_end) begin lat = i; break; end
    end
    r = data_out;
    tick;
    total++; if (r !== e || lat !== 15) begin bad++;
      $display("FAIL trig_wins got=%0h lat=%0d want=%0h", r, lat, e); end
    din = sext(longint'($urandom), D);
    model_step(din, e);
    run_sample(din, r, lat);
    total++; if (r !== e) begin bad++;
      $display("FAIL trig_wins_kept got=%0h want=%0h", r, e); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_scale();
    test_impulse();
    test_overrun();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
